sobel_mul_arbiter: RTL and testbench

- Shares one pipelined signed DATA_W x DATA_W multiplier between NUM_REQ requesters in the Sobel datapath, e.g. the Gx and Gy kernel accumulators.
- Round-robin arbitration with valid/ready request ports.
- Single tagged result port with backpressure.
- Replaces per-kernel multiplier instances, freeing DSP48 slices.

---
 rtl/sobel_mul_pkg.sv | 18 +
 rtl/sobel_mul_pipe.sv | 65 ++++++
 rtl/sobel_mul_arbiter.sv | 99 +++++++++
 tb/tb_sobel_mul_arbiter.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/sobel_mul_pkg.sv
// sobel_mul_pkg: shared defaults, requester-tag width helper and the S0 stage record
// for the Sobel multiplier arbiter.
package sobel_mul_pkg;
   localparam int DATA_W  = 11;
   localparam int PROD_W  = 20;
   localparam int MUL_LAT = 3;

   function automatic int id_w(input int num_req);
      return (num_req > 2) ? $clog2(num_req) : 1;
   endfunction

   typedef struct packed {
      logic                     valid;
      logic [id_w(2)-1:0]       id;
      logic signed [DATA_W-1:0] a;
      logic signed [DATA_W-1:0] b;
   } stage_t;
endpackage

// File: rtl/sobel_mul_pipe.sv
// sobel_mul_pipe: enable-gated signed multiplier, DEPTH registers deep, carrying
// the valid and requester-id side-band alongside the product.
module sobel_mul_pipe
   import sobel_mul_pkg::*;
#(
   parameter int DATA_W = sobel_mul_pkg::DATA_W,
   parameter int PROD_W = sobel_mul_pkg::PROD_W,
   parameter int ID_W   = 1,
   parameter int DEPTH  = sobel_mul_pkg::MUL_LAT - 1
) (
   input  logic                     ap_clk,
   input  logic                     ap_rst_n,
   input  logic                     en,
   input  logic                     flush,
   input  logic                     in_valid,
   input  logic [ID_W-1:0]          in_id,
   input  logic signed [DATA_W-1:0] in_a,
   input  logic signed [DATA_W-1:0] in_b,
   output logic                     out_valid,
   output logic [ID_W-1:0]          out_id,
   output logic [PROD_W-1:0]        out_data,
   output logic                     any_valid
);
   logic [DEPTH-1:0]             valid_q, valid_d;
   logic [DEPTH-1:0][ID_W-1:0]   id_q, id_d;
   logic [DEPTH-1:0][PROD_W-1:0] prod_q, prod_d;
   logic signed [PROD_W-1:0]     a_x, b_x;

   // Low PROD_W bits of the product of sign-extended operands equal the truncated full product.
   assign a_x = PROD_W'(in_a);
   assign b_x = PROD_W'(in_b);

   always_comb begin
      valid_d = valid_q;
      id_d    = id_q;
      prod_d  = prod_q;
      if (en) begin
         valid_d[0] = in_valid;
         id_d[0]    = in_id;
         prod_d[0]  = a_x * b_x;
         for (int s = 1; s < DEPTH; s++) begin
            valid_d[s] = valid_q[s-1];
            id_d[s]    = id_q[s-1];
            prod_d[s]  = prod_q[s-1];
         end
      end
      if (flush) valid_d = '0;
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n)
      if (!ap_rst_n) begin
         valid_q <= '0;
         id_q    <= '0;
         prod_q  <= '0;
      end else begin
         valid_q <= valid_d;
         id_q    <= id_d;
         prod_q  <= prod_d;
      end

   assign out_valid = valid_q[DEPTH-1];
   assign out_id    = id_q[DEPTH-1];
   assign out_data  = prod_q[DEPTH-1];
   assign any_valid = |valid_q;
endmodule

// File: rtl/sobel_mul_arbiter.sv
// sobel_mul_arbiter: round-robin arbiter sharing one pipelined signed multiplier
// between NUM_REQ requesters, with a tagged, backpressured result port.
module sobel_mul_arbiter
   import sobel_mul_pkg::*;
#(
   parameter int NUM_REQ = 2,
   parameter int DATA_W  = sobel_mul_pkg::DATA_W,
   parameter int PROD_W  = sobel_mul_pkg::PROD_W,
   parameter int MUL_LAT = sobel_mul_pkg::MUL_LAT,
   parameter int ID_W    = id_w(NUM_REQ)
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst_n,
   input  logic                      flush,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*DATA_W-1:0] req_a,
   input  logic [NUM_REQ*DATA_W-1:0] req_b,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [ID_W-1:0]           rsp_id,
   output logic [PROD_W-1:0]         rsp_data,
   output logic                      busy
);
   logic                     adv, hit, hs, pipe_busy;
   logic [ID_W-1:0]          gnt_idx, scan_idx, rr_ptr_q, rr_ptr_d;
   logic                     s0_valid_q, s0_valid_d;
   logic [ID_W-1:0]          s0_id_q, s0_id_d;
   logic signed [DATA_W-1:0] s0_a_q, s0_a_d, s0_b_q, s0_b_d, sel_a, sel_b;

   assign adv       = !rsp_valid || rsp_ready;
   assign hs        = ap_rst_n && adv && hit && !flush;
   assign req_ready = hs ? NUM_REQ'(1) << gnt_idx : '0;
   assign busy      = s0_valid_q || pipe_busy;

   // Scanning downward leaves the first valid requester at or after rr_ptr as the winner.
   always_comb begin
      hit      = 1'b0;
      gnt_idx  = '0;
      scan_idx = '0;
      sel_a    = '0;
      sel_b    = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         scan_idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (req_valid[scan_idx]) begin
            hit     = 1'b1;
            gnt_idx = scan_idx;
         end
      end
      for (int k = 0; k < NUM_REQ; k++)
         if (gnt_idx == ID_W'(k)) begin
            sel_a = req_a[k*DATA_W +: DATA_W];
            sel_b = req_b[k*DATA_W +: DATA_W];
         end
   end

   always_comb begin
      rr_ptr_d   = !hs ? rr_ptr_q : (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + ID_W'(1);
      s0_valid_d = flush ? 1'b0 : adv ? hs : s0_valid_q;
      s0_id_d    = hs ? gnt_idx : s0_id_q;
      s0_a_d     = hs ? sel_a : s0_a_q;
      s0_b_d     = hs ? sel_b : s0_b_q;
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n)
      if (!ap_rst_n) begin
         rr_ptr_q   <= '0;
         s0_valid_q <= 1'b0;
         s0_id_q    <= '0;
         s0_a_q     <= '0;
         s0_b_q     <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         s0_valid_q <= s0_valid_d;
         s0_id_q    <= s0_id_d;
         s0_a_q     <= s0_a_d;
         s0_b_q     <= s0_b_d;
      end

   sobel_mul_pipe #(
      .DATA_W (DATA_W),
      .PROD_W (PROD_W),
      .ID_W   (ID_W),
      .DEPTH  (MUL_LAT - 1)
   ) u_pipe (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .en        (adv),
      .flush     (flush),
      .in_valid  (s0_valid_q),
      .in_id     (s0_id_q),
      .in_a      (s0_a_q),
      .in_b      (s0_b_q),
      .out_valid (rsp_valid),
      .out_id    (rsp_id),
      .out_data  (rsp_data),
      .any_valid (pipe_busy)
   );
endmodule

// File: tb/tb_sobel_mul_arbiter.sv
// tb_sobel_mul_arbiter: directed and randomized stimulus checked against a
// transaction-level model of arbitration, latency, backpressure, flush and reset.
module tb_sobel_mul_arbiter;
   import sobel_mul_pkg::*;
   localparam int NR = 2;
   localparam int IW = 1;

   typedef struct {
      stage_t op;
      int     age;
   } ent_t;

   logic                 ap_clk = 1'b0, ap_rst_n = 1'b1, flush = 1'b0, rsp_ready = 1'b0;
   logic [NR-1:0]        req_valid = '0, req_ready;
   logic [NR*DATA_W-1:0] req_a = '0, req_b = '0;
   logic                 rsp_valid, busy;
   logic [IW-1:0]        rsp_id;
   logic [PROD_W-1:0]    rsp_data;
   int                   n_tests = 0, n_fail = 0;
   int                   ptr = 0;
   ent_t                 q[$];

   always #5 ap_clk = ~ap_clk;

   sobel_mul_arbiter #(.NUM_REQ(NR)) dut (
      .ap_clk    (ap_clk),
      .ap_rst_n  (ap_rst_n),
      .flush     (flush),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_a     (req_a),
      .req_b     (req_b),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_data  (rsp_data),
      .busy      (busy)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [PROD_W-1:0] ref_prod(input stage_t op);
      int pa, pb, p;
      pa = op.a;
      pb = op.b;
      p  = pa * pb;
      return p[PROD_W-1:0];
   endfunction

   // Each accepted op ages by one on every advancing edge and is presentable at age MUL_LAT.
   always @(negedge ap_clk) begin : mon
      logic          exp_rv, adv;
      logic [NR-1:0] exp_rdy;
      int            g, j;
      stage_t        s;
      ent_t          e;
      if (!ap_rst_n) begin
         q.delete();
         ptr = 0;
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_busy", busy, 0);
         chk("rst_req_ready", req_ready, 0);
      end else begin
         exp_rv = q.size() > 0 && q[0].age >= MUL_LAT;
         chk("rsp_valid", rsp_valid, exp_rv);
         chk("busy", busy, q.size() != 0);
         if (rsp_valid && exp_rv) begin
            chk("rsp_id", rsp_id, q[0].op.id);
            chk("rsp_data", rsp_data, ref_prod(q[0].op));
         end
         adv = !exp_rv || rsp_ready;
         g = -1;
         for (int k = 0; k < NR; k++) begin
            j = (ptr + k) % NR;
            if (g < 0 && ((req_valid >> j) & NR'(1)) != '0) g = j;
         end
         exp_rdy = (adv && !flush && g >= 0) ? NR'(1) << g : '0;
         chk("req_ready", req_ready, exp_rdy);
         if (flush) q.delete();
         else if (adv) begin
            if (exp_rv && rsp_ready) void'(q.pop_front());
            foreach (q[i]) q[i].age++;
            if (g >= 0) begin
               s.valid = 1'b1;
               s.id    = IW'(g);
               s.a     = req_a[g*DATA_W +: DATA_W];
               s.b     = req_b[g*DATA_W +: DATA_W];
               e.op    = s;
               e.age   = 1;
               q.push_back(e);
               ptr = (g + 1) % NR;
            end
         end
      end
   end

   task automatic step();
      @(posedge ap_clk);
      #1;
   endtask

   task automatic rand_ops();
      req_a = (NR*DATA_W)'($urandom);
      req_b = (NR*DATA_W)'($urandom);
   endtask

   task automatic single(input int r, input int a, input int b, input logic [PROD_W-1:0] exp);
      int n = 0;
      rsp_ready = 1'b1;
      flush     = 1'b0;
      req_valid = '0;
      while (busy && n < 20) begin
         step();
         n++;
      end
      chk("single_idle", busy, 0);
      req_a[r*DATA_W +: DATA_W] = DATA_W'(a);
      req_b[r*DATA_W +: DATA_W] = DATA_W'(b);
      req_valid[r] = 1'b1;
      #1;
      chk("single_hs", req_ready[r], 1);
      step();
      req_valid = '0;
      step();
      chk("single_early", rsp_valid, 0);
      step();
      chk("single_valid", rsp_valid, 1);
      chk("single_id", rsp_id, r);
      chk("single_data", rsp_data, exp);
   endtask

   initial begin
      #1 ap_rst_n = 1'b0;
      repeat (3) step();
      ap_rst_n = 1'b1;
      step();
      single(0, -3, 100, 20'hFFED4);
      single(1, 1023, 1023, 20'hFF801);
      single(0, -1024, -1024, 20'h00000);
      single(1, -1024, 1, 20'hFFC00);
      for (int i = 0; i < 8; i++) begin
         rand_ops();
         req_valid = '1;
         step();
      end
      rsp_ready = 1'b0;
      repeat (4) begin
         rand_ops();
         step();
      end
      rsp_ready = 1'b1;
      req_valid = '0;
      repeat (8) step();
      req_valid = '1;
      rand_ops();
      step();
      rand_ops();
      step();
      flush = 1'b1;
      #1 chk("flush_req_ready", req_ready, 0);
      step();
      flush     = 1'b0;
      req_valid = '0;
      chk("flush_busy", busy, 0);
      repeat (4) step();
      req_valid = '1;
      repeat (3) begin
         rand_ops();
         step();
      end
      chk("pre_rst_busy", busy, 1);
      #1 ap_rst_n = 1'b0;
      #1;
      chk("async_rsp_valid", rsp_valid, 0);
      chk("async_busy", busy, 0);
      chk("async_req_ready", req_ready, 0);
      step();
      step();
      ap_rst_n = 1'b1;
      #1 chk("rst_first_grant", req_ready, 2'b01);
      step();
      for (int i = 0; i < 3000; i++) begin
         req_valid = NR'($urandom);
         rand_ops();
         rsp_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         step();
      end
      flush     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (10) step();
      chk("drained", busy, 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
